// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fft_pkg                                                         |
// | Purpose  : Shared constants and width helpers for the FFT datapath blocks: |
// |            rounding-mode codes, twiddle Q-format and product widths.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package fft_pkg;

    // Rounding modes applied when a full-precision product is scaled down.
    localparam int ROUND_TRUNC   = 0;  // arithmetic shift, toward -inf
    localparam int ROUND_HALF_UP = 1;  // add half an LSB, then shift

    // Twiddles are Q1.(TW-1): one integer (sign) bit, the rest fractional.
    localparam int TW_INT_BITS = 1;

    function automatic int tw_frac_bits(input int tw);
        return tw - TW_INT_BITS;
    endfunction

    // x_re - x_im needs one extra bit over the data width.
    function automatic int data_preadd_width(input int dw_in);
        return dw_in + 1;
    endfunction

    // w_re +/- w_im needs one extra bit over the twiddle width.
    function automatic int tw_preadd_width(input int tw);
        return tw + 1;
    endfunction

    // Carrier width for the Karatsuba products and their sums. The final
    // sums R and I are bounded by 2^(DW_IN+TW-1), so two spare bits keep
    // the modular arithmetic exact even though partial products overshoot.
    function automatic int prod_width(input int dw_in, input int tw);
        return dw_in + tw + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_round_sat.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fft_round_sat                                                   |
// | Purpose  : Scales a full-width signed value by >>> SHIFT with optional     |
// |            round-half-up, then saturates (SAT=1) or wraps (SAT=0) to OW.   |
// | Ports    : i_data  - IW-bit signed full-precision input                    |
// |            o_data  - OW-bit signed scaled result                           |
// |            o_ovf   - result did not fit OW bits (clamped or wrapped)       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fft_round_sat
    import fft_pkg::*;
#(
    parameter int IW    = 36,
    parameter int OW    = 24,
    parameter int SHIFT = 9,
    parameter int ROUND = ROUND_HALF_UP,
    parameter int SAT   = 1
) (
    input  logic signed [IW-1:0] i_data,
    output logic signed [OW-1:0] o_data,
    output logic                 o_ovf
);

    // One guard bit so the rounding bias can never overflow the carrier.
    localparam int C_XW = IW + 1;

    logic signed [C_XW-1:0] w_ext;
    logic signed [C_XW-1:0] w_bias;
    logic signed [C_XW-1:0] w_rnd;
    logic signed [C_XW-1:0] w_shf;

    assign w_ext = C_XW'(i_data);

    generate
        if (ROUND == ROUND_HALF_UP && SHIFT > 0) begin : g_round
            localparam logic signed [C_XW-1:0] C_HALF = C_XW'(1) <<< (SHIFT - 1);
            assign w_bias = C_HALF;
        end else begin : g_trunc
            assign w_bias = '0;
        end
    endgenerate

    assign w_rnd = w_ext + w_bias;
    assign w_shf = w_rnd >>> SHIFT;

    generate
        if (OW < C_XW) begin : g_narrow
            logic w_fits;
            // Fits when re-sign-extending the low OW bits reproduces the value.
            assign w_fits = (w_shf == C_XW'(signed'(w_shf[OW-1:0])));
            assign o_ovf  = ~w_fits;

            if (SAT != 0) begin : g_sat
                localparam logic signed [OW-1:0] C_MAX = {1'b0, {(OW-1){1'b1}}};
                localparam logic signed [OW-1:0] C_MIN = {1'b1, {(OW-1){1'b0}}};
                assign o_data = w_fits ? w_shf[OW-1:0]
                                       : (w_shf[C_XW-1] ? C_MIN : C_MAX);
            end else begin : g_wrap
                assign o_data = w_shf[OW-1:0];
            end
        end else begin : g_wide
            assign o_data = OW'(w_shf);
            assign o_ovf  = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/fft_twiddle_mult_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fft_twiddle_mult_pipe                                           |
// | Purpose  : 3-stage pipelined complex twiddle multiplier z = x * w using a  |
// |            3-multiplier Karatsuba form, with rounding, saturation/wrap,    |
// |            sticky overflow and a W=1 bypass. Valid/ctr ride along.        |
// | Ports    : clk_i, rst_n_i (async active-low), ce_i (pipeline advance)      |
// |            valid_i, bypass_i, ctr_i, x_re_i/x_im_i, w_re_i/w_im_i          |
// |            clr_ovf_i - clears the sticky overflow (a new set wins)         |
// |            valid_o, ctr_o, z_re_o/z_im_o, ovf_o                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fft_twiddle_mult_pipe
    import fft_pkg::*;
#(
    parameter int DW_IN  = 24,
    parameter int DW_OUT = 24,
    parameter int TW     = 10,
    parameter int NLOG2  = 10,
    parameter int ROUND  = ROUND_HALF_UP,
    parameter int SAT    = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     ce_i,
    input  logic                     valid_i,
    input  logic                     bypass_i,
    input  logic        [NLOG2-1:0]  ctr_i,
    input  logic signed [DW_IN-1:0]  x_re_i,
    input  logic signed [DW_IN-1:0]  x_im_i,
    input  logic signed [TW-1:0]     w_re_i,
    input  logic signed [TW-1:0]     w_im_i,
    input  logic                     clr_ovf_i,
    output logic                     valid_o,
    output logic        [NLOG2-1:0]  ctr_o,
    output logic signed [DW_OUT-1:0] z_re_o,
    output logic signed [DW_OUT-1:0] z_im_o,
    output logic                     ovf_o
);

    localparam int C_EW    = data_preadd_width(DW_IN);
    localparam int C_VW    = tw_preadd_width(TW);
    localparam int C_PW    = prod_width(DW_IN, TW);
    localparam int C_SHIFT = tw_frac_bits(TW);

    // ---------------- S1: capture inputs and form pre-adds ----------------
    logic signed [C_EW-1:0]  w_e;
    logic signed [C_VW-1:0]  w_wd;
    logic signed [C_VW-1:0]  w_ws;

    assign w_e  = C_EW'(x_re_i) - C_EW'(x_im_i);
    assign w_wd = C_VW'(w_re_i) - C_VW'(w_im_i);
    assign w_ws = C_VW'(w_re_i) + C_VW'(w_im_i);

    logic                    r_s1_valid;
    logic                    r_s1_bypass;
    logic        [NLOG2-1:0] r_s1_ctr;
    logic signed [DW_IN-1:0] r_s1_x_re;
    logic signed [DW_IN-1:0] r_s1_x_im;
    logic signed [TW-1:0]    r_s1_w_re;
    logic signed [C_EW-1:0]  r_s1_e;
    logic signed [C_VW-1:0]  r_s1_wd;
    logic signed [C_VW-1:0]  r_s1_ws;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_s1_valid  <= 1'b0;
            r_s1_bypass <= 1'b0;
            r_s1_ctr    <= '0;
            r_s1_x_re   <= '0;
            r_s1_x_im   <= '0;
            r_s1_w_re   <= '0;
            r_s1_e      <= '0;
            r_s1_wd     <= '0;
            r_s1_ws     <= '0;
        end else if (ce_i) begin
            r_s1_valid  <= valid_i;
            r_s1_bypass <= bypass_i;
            r_s1_ctr    <= ctr_i;
            r_s1_x_re   <= x_re_i;
            r_s1_x_im   <= x_im_i;
            r_s1_w_re   <= w_re_i;
            r_s1_e      <= w_e;
            r_s1_wd     <= w_wd;
            r_s1_ws     <= w_ws;
        end
    end

    // ---------------- S2: three signed products ----------------
    logic                    r_s2_valid;
    logic                    r_s2_bypass;
    logic        [NLOG2-1:0] r_s2_ctr;
    logic signed [DW_IN-1:0] r_s2_x_re;
    logic signed [DW_IN-1:0] r_s2_x_im;
    logic signed [C_PW-1:0]  r_s2_f;
    logic signed [C_PW-1:0]  r_s2_pr;
    logic signed [C_PW-1:0]  r_s2_pi;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_s2_valid  <= 1'b0;
            r_s2_bypass <= 1'b0;
            r_s2_ctr    <= '0;
            r_s2_x_re   <= '0;
            r_s2_x_im   <= '0;
            r_s2_f      <= '0;
            r_s2_pr     <= '0;
            r_s2_pi     <= '0;
        end else if (ce_i) begin
            r_s2_valid  <= r_s1_valid;
            r_s2_bypass <= r_s1_bypass;
            r_s2_ctr    <= r_s1_ctr;
            r_s2_x_re   <= r_s1_x_re;
            r_s2_x_im   <= r_s1_x_im;
            r_s2_f      <= C_PW'(r_s1_w_re) * C_PW'(r_s1_e);
            r_s2_pr     <= C_PW'(r_s1_x_im) * C_PW'(r_s1_wd);
            r_s2_pi     <= C_PW'(r_s1_x_re) * C_PW'(r_s1_ws);
        end
    end

    // ---------------- S3: combine, scale, saturate ----------------
    logic signed [C_PW-1:0]   w_r;
    logic signed [C_PW-1:0]   w_i;
    logic signed [C_PW-1:0]   w_re_full;
    logic signed [C_PW-1:0]   w_im_full;
    logic signed [DW_OUT-1:0] w_z_re;
    logic signed [DW_OUT-1:0] w_z_im;
    logic                     w_ovf_re;
    logic                     w_ovf_im;
    logic                     w_ovf_set;

    assign w_r = r_s2_pr + r_s2_f;
    assign w_i = r_s2_pi - r_s2_f;

    // Bypass pre-scales x up by the same shift the scaler removes. The low
    // bits are then zero, so the half-LSB bias never carries and x comes
    // out exactly, while still going through the common saturate/wrap path.
    assign w_re_full = r_s2_bypass ? (C_PW'(r_s2_x_re) <<< C_SHIFT) : w_r;
    assign w_im_full = r_s2_bypass ? (C_PW'(r_s2_x_im) <<< C_SHIFT) : w_i;

    fft_round_sat #(
        .IW    (C_PW),
        .OW    (DW_OUT),
        .SHIFT (C_SHIFT),
        .ROUND (ROUND),
        .SAT   (SAT)
    ) u_round_sat_re (
        .i_data (w_re_full),
        .o_data (w_z_re),
        .o_ovf  (w_ovf_re)
    );

    fft_round_sat #(
        .IW    (C_PW),
        .OW    (DW_OUT),
        .SHIFT (C_SHIFT),
        .ROUND (ROUND),
        .SAT   (SAT)
    ) u_round_sat_im (
        .i_data (w_im_full),
        .o_data (w_z_im),
        .o_ovf  (w_ovf_im)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_o <= 1'b0;
            ctr_o   <= '0;
            z_re_o  <= '0;
            z_im_o  <= '0;
        end else if (ce_i) begin
            valid_o <= r_s2_valid;
            ctr_o   <= r_s2_ctr;
            z_re_o  <= w_z_re;
            z_im_o  <= w_z_im;
        end
    end

    // Only a valid sample actually leaving S3 may raise the flag; the clear
    // works even while the pipeline is stalled, and a coincident set wins.
    assign w_ovf_set = ce_i & r_s2_valid & (w_ovf_re | w_ovf_im);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ovf_o <= 1'b0;
        end else if (w_ovf_set) begin
            ovf_o <= 1'b1;
        end else if (clr_ovf_i) begin
            ovf_o <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_twiddle_mult_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fft_twiddle_mult_pipe                                        |
// | Purpose  : Self-checking bench for fft_twiddle_mult_pipe. Two instances    |
// |            share stimulus: 24-bit out/round/saturate and 16-bit out/       |
// |            truncate/wrap. A plain-arithmetic model predicts every cycle.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_fft_twiddle_mult_pipe;

    localparam int DWI  = 24;
    localparam int DWO0 = 24;
    localparam int DWO1 = 16;
    localparam int TWP  = 10;
    localparam int NL   = 10;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   ce = 1'b1;
    logic                   valid = 1'b0;
    logic                   bypass = 1'b0;
    logic        [NL-1:0]   ctr = '0;
    logic signed [DWI-1:0]  x_re = '0;
    logic signed [DWI-1:0]  x_im = '0;
    logic signed [TWP-1:0]  w_re = '0;
    logic signed [TWP-1:0]  w_im = '0;
    logic                   clr = 1'b0;

    logic                   v0, o0, v1, o1;
    logic        [NL-1:0]   c0, c1;
    logic signed [DWO0-1:0] zr0, zi0;
    logic signed [DWO1-1:0] zr1, zi1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fft_twiddle_mult_pipe #(
        .DW_IN(DWI), .DW_OUT(DWO0), .TW(TWP), .NLOG2(NL), .ROUND(1), .SAT(1)
    ) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce), .valid_i(valid), .bypass_i(bypass),
        .ctr_i(ctr), .x_re_i(x_re), .x_im_i(x_im), .w_re_i(w_re), .w_im_i(w_im),
        .clr_ovf_i(clr), .valid_o(v0), .ctr_o(c0), .z_re_o(zr0), .z_im_o(zi0),
        .ovf_o(o0)
    );

    fft_twiddle_mult_pipe #(
        .DW_IN(DWI), .DW_OUT(DWO1), .TW(TWP), .NLOG2(NL), .ROUND(0), .SAT(0)
    ) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce), .valid_i(valid), .bypass_i(bypass),
        .ctr_i(ctr), .x_re_i(x_re), .x_im_i(x_im), .w_re_i(w_re), .w_im_i(w_im),
        .clr_ovf_i(clr), .valid_o(v1), .ctr_o(c1), .z_re_o(zr1), .z_im_o(zi1),
        .ovf_o(o1)
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        bit     valid;
        bit     byp;
        int     ctr;
        longint xr, xi, wr, wi;
    } rec_t;

    rec_t q[$];
    bit   m_ovf0 = 1'b0;
    bit   m_ovf1 = 1'b0;

    function automatic longint fit(input longint v, input int dwo, input bit sat,
                                   output bit ov);
        longint span, mx, mn, m;
        span = longint'(1) <<< dwo;
        mx   = span / 2 - 1;
        mn   = -(span / 2);
        ov   = (v > mx) || (v < mn);
        if (!ov)      m = v;
        else if (sat) m = (v > mx) ? mx : mn;
        else begin
            m = v & (span - 1);
            if (m > mx) m = m - span;
        end
        return m;
    endfunction

    // z = x*w in Q1.(TW-1), computed directly as a complex product.
    function automatic void model(input rec_t r, input int dwo, input bit rnd,
                                  input bit sat, output longint zr, output longint zi,
                                  output bit ov);
        longint re, im;
        bit     ovr, ovi;
        if (r.byp) begin
            re = r.xr;
            im = r.xi;
        end else begin
            re = r.xr * r.wr - r.xi * r.wi;
            im = r.xr * r.wi + r.xi * r.wr;
            if (rnd) begin
                re = re + (64'sd1 <<< (TWP - 2));
                im = im + (64'sd1 <<< (TWP - 2));
            end
            re = re >>> (TWP - 1);
            im = im >>> (TWP - 1);
        end
        zr = fit(re, dwo, sat, ovr);
        zi = fit(im, dwo, sat, ovi);
        ov = ovr | ovi;
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // The model accepts one sample per ce-high edge; the output after an
    // edge is the sample accepted three ce-high edges earlier.
    initial forever begin
        rec_t   cur, h;
        longint zr, zi;
        bit     ov;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete();
            m_ovf0 = 1'b0;
            m_ovf1 = 1'b0;
        end else begin
            if (ce) begin
                cur.valid = valid;
                cur.byp   = bypass;
                cur.ctr   = int'(ctr);
                cur.xr    = longint'(x_re);
                cur.xi    = longint'(x_im);
                cur.wr    = longint'(w_re);
                cur.wi    = longint'(w_im);
                q.push_back(cur);
                if (q.size() > 3) void'(q.pop_front());
            end
            if (ce && q.size() == 3 && q[0].valid) begin
                h = q[0];
                model(h, DWO0, 1'b1, 1'b1, zr, zi, ov);
                if (ov) m_ovf0 = 1'b1; else if (clr) m_ovf0 = 1'b0;
                model(h, DWO1, 1'b0, 1'b0, zr, zi, ov);
                if (ov) m_ovf1 = 1'b1; else if (clr) m_ovf1 = 1'b0;
            end else if (clr) begin
                m_ovf0 = 1'b0;
                m_ovf1 = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        rec_t   e;
        longint er0, ei0, er1, ei1;
        bit     ov;
        @(posedge clk);
        #2;
        if (q.size() == 3) begin
            e = q[0];
            model(e, DWO0, 1'b1, 1'b1, er0, ei0, ov);
            model(e, DWO1, 1'b0, 1'b0, er1, ei1, ov);
        end else begin
            e = '{valid: 1'b0, byp: 1'b0, ctr: 0, xr: 0, xi: 0, wr: 0, wi: 0};
            er0 = 0; ei0 = 0; er1 = 0; ei1 = 0;
        end
        check("valid0", longint'(v0), longint'(e.valid));
        check("ctr0",   longint'(c0), longint'(e.ctr));
        check("zre0",   longint'(zr0), er0);
        check("zim0",   longint'(zi0), ei0);
        check("ovf0",   longint'(o0), longint'(m_ovf0));
        check("valid1", longint'(v1), longint'(e.valid));
        check("ctr1",   longint'(c1), longint'(e.ctr));
        check("zre1",   longint'(zr1), er1);
        check("zim1",   longint'(zi1), ei1);
        check("ovf1",   longint'(o1), longint'(m_ovf1));
    end

    // ---------------- stimulus helpers ----------------
    task automatic pin(input string nm, input longint xr, input longint xi,
                       input longint wr, input longint wi, input bit rnd,
                       input longint exr, input longint exi, input bit exov);
        rec_t   r;
        longint zr, zi;
        bit     ov;
        r = '{valid: 1'b1, byp: 1'b0, ctr: 0, xr: xr, xi: xi, wr: wr, wi: wi};
        model(r, DWO0, rnd, 1'b1, zr, zi, ov);
        check({nm, "_re"}, zr, exr);
        check({nm, "_im"}, zi, exi);
        check({nm, "_ov"}, longint'(ov), longint'(exov));
    endtask

    // Drive one valid sample and check dut0 three ce-edges later.
    task automatic send_check(input string nm, input int xr, input int xi,
                              input int wr, input int wi, input int c,
                              input longint exr, input longint exi);
        @(negedge clk);
        valid = 1'b1; bypass = 1'b0; ctr = NL'(c);
        x_re = DWI'(xr); x_im = DWI'(xi); w_re = TWP'(wr); w_im = TWP'(wi);
        @(negedge clk);
        valid = 1'b0;
        repeat (2) @(negedge clk);
        check({nm, "_valid"}, longint'(v0), 1);
        check({nm, "_ctr"},   longint'(c0), longint'(c));
        check({nm, "_re"},    longint'(zr0), exr);
        check({nm, "_im"},    longint'(zi0), exi);
    endtask

    task automatic rand_inputs();
        valid  = 1'($urandom);
        bypass = ($urandom_range(0, 3) == 0);
        ctr    = NL'($urandom);
        case ($urandom_range(0, 5))
            0:       x_re = {1'b1, {(DWI-1){1'b0}}};
            1:       x_re = {1'b0, {(DWI-1){1'b1}}};
            default: x_re = DWI'($urandom);
        endcase
        x_im = ($urandom_range(0, 4) == 0) ? {1'b1, {(DWI-1){1'b0}}} : DWI'($urandom);
        w_re = TWP'($urandom);
        w_im = TWP'($urandom);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", longint'(v0), 0);
        check("rst_z",     longint'(zr0), 0);
        check("rst_ovf",   longint'(o0), 0);
        rst_n = 1'b1;

        // Pin the model to hand-derived results.
        pin("m_ident",  1000, -500, 511, 0,    1'b1, 998,     -499,  1'b0);
        pin("m_rotj",   1000, -500, 0,   -512, 1'b1, -500,    -1000, 1'b0);
        pin("m_rnd1",   1,    0,    256, 0,    1'b1, 1,       0,     1'b0);
        pin("m_rnd0",   1,    0,    256, 0,    1'b0, 0,       0,     1'b0);
        pin("m_sat",    -8388608, 0, -512, 0,  1'b1, 8388607, 0,     1'b1);

        // Directed DUT cases.
        send_check("ident", 1000, -500, 511, 0, 'h155, 998, -499);
        send_check("rotj",  1000, -500, 0, -512, 'h2aa, -500, -1000);
        check("rotj_ovf", longint'(o0), 0);
        send_check("round", 1, 0, 256, 0, 7, 1, 0);
        check("trunc_re", longint'(zr1), 0);
        send_check("sat", -8388608, 0, -512, 0, 9, 8388607, 0);
        check("sat_ovf", longint'(o0), 1);
        repeat (3) @(negedge clk);
        check("sat_hold", longint'(o0), 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_ovf", longint'(o0), 0);

        // Set and clear landing on the same edge: set must win.
        @(negedge clk);
        valid = 1'b1; x_re = {1'b1, {(DWI-1){1'b0}}}; x_im = '0;
        w_re = {1'b1, {(TWP-1){1'b0}}}; w_im = '0;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("set_wins", longint'(o0), 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;

        // 8-sample bypass burst with a 5-cycle stall in the middle.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            ce = !(i >= 4 && i < 9);
            if (ce) begin
                rand_inputs();
                valid  = 1'b1;
                bypass = 1'b1;
                ctr    = NL'(i);
            end
        end
        @(negedge clk);
        ce = 1'b1; valid = 1'b0; bypass = 1'b0;
        repeat (4) @(negedge clk);

        // Randomized stream with random stalls and clears.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rand_inputs();
            ce  = ($urandom_range(0, 99) < 85);
            clr = ($urandom_range(0, 15) == 0);
        end
        @(negedge clk);
        ce = 1'b1; clr = 1'b0;

        // Reset with two samples in flight.
        valid = 1'b1; x_re = DWI'(12345); x_im = DWI'(-777);
        w_re = TWP'(300); w_im = TWP'(-100);
        @(negedge clk);
        x_re = DWI'(-4000);
        @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", longint'(v0), 0);
        check("mid_rst_ctr",   longint'(c0), 0);
        check("mid_rst_zre",   longint'(zr0), 0);
        check("mid_rst_zim",   longint'(zi0), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_valid", longint'(v0), 0);
        send_check("post_rst", 1000, -500, 511, 0, 3, 998, -499);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
